aurva_coeff_packer: RTL and testbench
=====================================

# aurva_coeff_packer

Packs the NTT engine's one-coefficient-per-beat result stream into 256-bit AXI4-Stream beats for the AXI write master. It sits directly downstream of the convolution FSM and directly upstream of the write master. Each 27-bit coefficient is zero-extended into a 32-bit lane; eight lanes form one beat. A partial final beat is zero-padded and tagged through `tkeep`.

## Interface
- `C_AXIS_TDATA_WIDTH`, 256: output beat width; must be a multiple of `C_LANE_WIDTH`.
- `C_LANE_WIDTH`, 32: bits per coefficient lane in memory.
- `C_COEFF_WIDTH`, 27: significant coefficient bits; must be ≤ `C_LANE_WIDTH`.
- Derived: `LP_LANES = C_AXIS_TDATA_WIDTH/C_LANE_WIDTH` (8).
- Clock and reset are decided: one clock; reset is asynchronous and active-low.
- `aclk` in 1: sole clock.
- `areset_n` in 1: asynchronous, active-low reset.
- `s_axis_tvalid` in 1: coefficient valid.
- `s_axis_tready` out 1: coefficient accepted when high with `s_axis_tvalid`.
- `s_axis_tdata` in `C_COEFF_WIDTH`: coefficient.
- `s_axis_tlast` in 1: last coefficient of the transfer.
- `m_axis_tvalid` out 1: packed beat valid.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tdata` out `C_AXIS_TDATA_WIDTH`: lane i = bits [32i+31:32i].
- `m_axis_tkeep` out `C_AXIS_TDATA_WIDTH/8`: byte enables; 4 bits per lane.
- `m_axis_tlast` out 1: beat holds the transfer's final coefficient.
- `packet_done` out 1: one-cycle pulse when the tlast beat handshakes downstream.

## Operation
- Lane index counter `idx` runs 0..`LP_LANES-1`.
- Assembly buffer holds lanes 0..`LP_LANES-2`. Output register holds one complete beat; `out_full` flags it.
- On input handshake:
  - The coefficient is zero-extended into lane `idx`.
  - If `idx == LP_LANES-1` or `s_axis_tlast`, the beat completes:
    - The output register loads the buffered lanes plus the current coefficient.
    - Lanes above `idx` are forced to 0.
    - `tkeep` = 4·(`idx`+1) low-order ones; `tlast` = `s_axis_tlast`.
    - `idx` returns to 0 and the buffer clears.
  - Otherwise `idx` increments.
- `s_axis_tready = areset_n_sync_high && (!out_full || m_axis_tready)`. It is independent of `s_axis_tvalid` and `tlast`.
- Output handshake (`m_axis_tvalid && m_axis_tready`) clears `out_full`. A beat completing in the same cycle sets it again, so the register reloads with no bubble.
- `packet_done` is registered and asserts in the cycle after the output handshake of a beat with `m_axis_tlast=1`.
- Coefficient bits above `C_COEFF_WIDTH` in each lane are always 0.

## Timing
- Reset values (asynchronous, while `areset_n`=0):
  - `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tkeep`=0, `m_axis_tlast`=0.
  - `packet_done`=0, `idx`=0, buffer=0, `s_axis_tready`=0.
- `s_axis_tready` rises in the first cycle after reset deasserts.
- Latency: a completing coefficient accepted at edge N gives `m_axis_tvalid`=1 from edge N (visible in cycle N+1).
- Throughput: 1 coefficient/cycle while `m_axis_tready`=1, i.e. one beat per 8 cycles.
- Stall: while `out_full && !m_axis_tready`, `s_axis_tready`=0. The output register stays stable; AXIS rule, no data change while valid and not ready.
- Reset mid-transfer discards the partial assembly and any held beat. No partial beat is emitted afterwards.
- Back-to-back transfers: a coefficient after a tlast starts a new beat at lane 0 in the next cycle.

## Structure
- Shared package `aurva_pkg` holds:
  - `LP_LANES`, the lane width, and the coefficient width (27).
  - Function `lanes_to_tkeep(idx)`, which returns the byte-enable mask.
  - The debug widths shared with the NTT datapath.
- No sub-module. Counter, buffer and output register live in one module of about 150 lines.

## Test plan
- **Full packing:** 16 coefficients 1..16, `tlast` on 16, `m_axis_tready`=1 → two beats:
  - Lanes 1..8, `tkeep`=32'hFFFFFFFF, `tlast`=0.
  - Lanes 9..16, `tkeep`=32'hFFFFFFFF, `tlast`=1.
  - `packet_done` pulses once.
- **Partial beat:** 3 coefficients 27'h7FFFFFF, 5, 6 with `tlast` on the third → one beat:
  - Lane0=32'h07FFFFFF, lane1=5, lane2=6, lanes 3..7=0.
  - `tkeep`=32'h00000FFF, `tlast`=1.
- **Single-coefficient transfer:** `tlast` on lane 0 → `tkeep`=32'h0000000F. The next transfer starts at lane 0.
- **Backpressure:** hold `m_axis_tready`=0 after the first beat completes, keep `s_axis_tvalid`=1 → `s_axis_tready`=0 and `m_axis_tdata` stable for the whole stall. Releasing `tready` resumes with no lost or duplicated coefficients over a 64-coefficient random stream, checked against a scoreboard.
- **Random throttling:** randomised `s_axis_tvalid` / `m_axis_tready` (50%) over 1000 coefficients → output identical to the reference packing, and zero bubbles whenever both sides are continuously ready.
- **Reset mid-operation:** assert `areset_n`=0 after 5 of 8 coefficients, then send 8 new ones → exactly one beat containing only the new 8. All outputs are 0 during reset.

Source files
------------

// File: rtl/aurva_pkg.sv
// Shared constants and helpers for the NTT result path and the coefficient packer.
package aurva_pkg;

  localparam int unsigned C_AXIS_TDATA_WIDTH = 256;
  localparam int unsigned C_LANE_WIDTH       = 32;
  localparam int unsigned C_COEFF_WIDTH      = 27;
  localparam int unsigned LP_LANES           = C_AXIS_TDATA_WIDTH / C_LANE_WIDTH;
  localparam int unsigned LP_KEEP_W          = C_AXIS_TDATA_WIDTH / 8;
  localparam int unsigned LP_IDX_W           = $clog2(LP_LANES);
  localparam int unsigned LP_LANE_BYTES      = C_LANE_WIDTH / 8;

  // Debug observation widths shared with the NTT datapath.
  localparam int unsigned LP_DBG_IDX_W       = LP_IDX_W;
  localparam int unsigned LP_DBG_STAGE_W     = 4;
  localparam int unsigned LP_DBG_BUS_W       = 16;

  // Byte-enable mask covering lanes 0..idx inclusive.
  function automatic logic [LP_KEEP_W-1:0] lanes_to_tkeep(input logic [LP_IDX_W-1:0] idx);
    logic [LP_KEEP_W-1:0] keep;
    keep = '0;
    for (int i = 0; i < int'(LP_LANES); i++) begin
      if (LP_IDX_W'(i) <= idx) keep[i*LP_LANE_BYTES +: LP_LANE_BYTES] = '1;
    end
    return keep;
  endfunction

endpackage

// File: rtl/aurva_coeff_packer_if.sv
// Coefficient input stream and packed-beat output stream seen by the packer.
interface aurva_coeff_packer_if;
  import aurva_pkg::*;

  logic                          s_axis_tvalid;
  logic                          s_axis_tready;
  logic [C_COEFF_WIDTH-1:0]      s_axis_tdata;
  logic                          s_axis_tlast;
  logic                          m_axis_tvalid;
  logic                          m_axis_tready;
  logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata;
  logic [LP_KEEP_W-1:0]          m_axis_tkeep;
  logic                          m_axis_tlast;

  // Packer side.
  modport slave (
    input  s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

  // Upstream producer / downstream consumer side.
  modport master (
    output s_axis_tvalid, s_axis_tdata, s_axis_tlast, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast
  );

endinterface

// File: rtl/aurva_coeff_packer.sv
// Packs one 27-bit coefficient per beat into 8-lane 256-bit AXI4-Stream beats.
module aurva_coeff_packer
  import aurva_pkg::*;
(
  input  logic                 aclk,
  input  logic                 areset_n,
  aurva_coeff_packer_if.slave  axis,
  output logic                 packet_done
);

  logic [LP_IDX_W-1:0]                     idx_q;
  logic [LP_LANES-2:0][C_LANE_WIDTH-1:0]   asm_q;
  logic                                    ready_en_q;
  logic                                    out_full_q;
  logic [C_AXIS_TDATA_WIDTH-1:0]           data_q;
  logic [LP_KEEP_W-1:0]                    keep_q;
  logic                                    last_q;

  logic                                    in_hs_c;
  logic                                    out_hs_c;
  logic                                    beat_done_c;
  logic [C_LANE_WIDTH-1:0]                 lane_c;
  logic [LP_LANES-1:0][C_LANE_WIDTH-1:0]   beat_c;

  // Input is accepted whenever the output register is free or draining this cycle.
  assign axis.s_axis_tready = ready_en_q && (!out_full_q || axis.m_axis_tready);
  assign axis.m_axis_tvalid = out_full_q;
  assign axis.m_axis_tdata  = data_q;
  assign axis.m_axis_tkeep  = keep_q;
  assign axis.m_axis_tlast  = last_q;

  assign in_hs_c     = axis.s_axis_tvalid && axis.s_axis_tready;
  assign out_hs_c    = out_full_q && axis.m_axis_tready;
  assign beat_done_c = in_hs_c && ((idx_q == LP_IDX_W'(LP_LANES - 1)) || axis.s_axis_tlast);
  assign lane_c      = C_LANE_WIDTH'(axis.s_axis_tdata);

  // Completed beat: buffered lanes below idx, current coefficient at idx, zeros above.
  always_comb begin
    beat_c = '0;
    for (int i = 0; i < int'(LP_LANES) - 1; i++) begin
      if (LP_IDX_W'(i) < idx_q) beat_c[i] = asm_q[i];
    end
    beat_c[idx_q] = lane_c;
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      idx_q       <= '0;
      asm_q       <= '0;
      ready_en_q  <= 1'b0;
      out_full_q  <= 1'b0;
      data_q      <= '0;
      keep_q      <= '0;
      last_q      <= 1'b0;
      packet_done <= 1'b0;
    end else begin
      ready_en_q  <= 1'b1;
      packet_done <= out_hs_c && last_q;

      if (out_hs_c) out_full_q <= 1'b0;

      if (beat_done_c) begin
        out_full_q <= 1'b1;
        data_q     <= beat_c;
        keep_q     <= lanes_to_tkeep(idx_q);
        last_q     <= axis.s_axis_tlast;
        idx_q      <= '0;
        asm_q      <= '0;
      end else if (in_hs_c) begin
        asm_q[idx_q] <= lane_c;
        idx_q        <= idx_q + LP_IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_aurva_coeff_packer.sv
// Directed and randomised bench for the coefficient packer, checked against a queue-based packing model.
module tb_aurva_coeff_packer;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } beat_t;

  logic aclk;
  logic areset_n;
  logic packet_done;

  aurva_coeff_packer_if bus();

  aurva_coeff_packer dut (
    .aclk        (aclk),
    .areset_n    (areset_n),
    .axis        (bus.slave),
    .packet_done (packet_done)
  );

  int checks = 0;
  int errors = 0;
  int mode   = 0;   // 0: tready high, 1: random tready, 2: tready held low
  int cyc    = 0;
  int hi_edges = 0;
  int pd_cnt = 0;

  logic [26:0] part[$];
  beat_t       exp_q[$];
  beat_t       obs[$];
  logic        prev_last;
  logic        prev_stall;
  beat_t       stall_beat;

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  always @(posedge aclk or negedge areset_n) begin
    if (!areset_n) hi_edges <= 0;
    else if (hi_edges < 4) hi_edges <= hi_edges + 1;
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] lane_of(input beat_t b, input int k);
    return b.data[k*32 +: 32];
  endfunction

  // Reference packing: gather up to eight coefficients, pad the rest with zeros.
  function automatic beat_t pack_model(input logic [26:0] c[$], input logic last);
    beat_t b;
    b.data = '0;
    for (int k = 0; k < c.size(); k++) b.data[k*32 +: 32] = {5'b0, c[k]};
    b.keep = 32'((64'd1 << (4 * c.size())) - 64'd1);
    b.last = last;
    return b;
  endfunction

  // Per-cycle compare against the model, sampled on the falling edge.
  always @(negedge aclk) begin
    beat_t cur;
    beat_t e;
    logic  exp_full;
    cur = '{data: bus.m_axis_tdata, keep: bus.m_axis_tkeep, last: bus.m_axis_tlast};
    if (packet_done === 1'b1) pd_cnt++;
    if (!areset_n) begin
      chk("reset_ctrl", 256'({bus.m_axis_tvalid, bus.m_axis_tlast, packet_done, bus.s_axis_tready}), 256'd0);
      chk("reset_data", 256'({bus.m_axis_tdata ^ 256'd0, bus.m_axis_tkeep} != 0), 256'd0);
      exp_q.delete();
      part.delete();
      prev_last  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      exp_full = exp_q.size() > 0;
      chk("m_tvalid", 256'(bus.m_axis_tvalid), 256'(exp_full));
      chk("s_tready", 256'(bus.s_axis_tready),
          256'((hi_edges > 0) && (!exp_full || bus.m_axis_tready)));
      chk("packet_done", 256'(packet_done), 256'(prev_last));
      if (prev_stall) chk("stall_stable", 256'(cur), 256'(stall_beat));
      prev_last = 1'b0;
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_beat: got %h expected none", cur.data);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", cur.data, e.data);
          chk("beat_keep", 256'(cur.keep), 256'(e.keep));
          chk("beat_last", 256'(cur.last), 256'(e.last));
          prev_last = e.last;
        end
        obs.push_back(cur);
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      stall_beat = cur;
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        part.push_back(bus.s_axis_tdata);
        if (part.size() == 8 || bus.s_axis_tlast) begin
          exp_q.push_back(pack_model(part, bus.s_axis_tlast));
          part.delete();
        end
      end
    end
  end

  initial begin
    bus.m_axis_tready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      case (mode)
        0:       bus.m_axis_tready = 1'b1;
        1:       bus.m_axis_tready = 1'($urandom_range(0, 1));
        default: bus.m_axis_tready = 1'b0;
      endcase
    end
  end

  // Present one coefficient and hold it until accepted; optional random idle gap first.
  task automatic send(input logic [26:0] d, input logic l, input bit gap);
    bit hs;
    if (gap && $urandom_range(0, 1) == 1) begin
      bus.s_axis_tvalid = 1'b0;
      repeat ($urandom_range(1, 2)) @(posedge aclk);
      #1;
    end
    bus.s_axis_tvalid = 1'b1;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    for (int n = 0; n < 5000; n++) begin
      @(negedge aclk);
      hs = bus.s_axis_tready;
      @(posedge aclk);
      #1;
      if (hs) return;
    end
    errors++;
    checks++;
    $display("FAIL send_timeout: got no s_tready expected acceptance of %h", d);
  endtask

  task automatic idle();
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 500; n++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && !bus.m_axis_tvalid) begin
        repeat (2) @(posedge aclk);
        #1;
        return;
      end
    end
    errors++;
    checks++;
    $display("FAIL drain_timeout: got %0d pending beats expected 0", exp_q.size());
  endtask

  initial begin
    int b;
    int c0;
    int p0;
    bus.s_axis_tvalid = 1'b0;
    bus.s_axis_tdata  = '0;
    bus.s_axis_tlast  = 1'b0;
    areset_n = 1'b0;
    repeat (3) @(posedge aclk);
    #1 areset_n = 1'b1;
    @(posedge aclk);
    #1;

    // Full packing, continuous flow.
    b = obs.size(); p0 = pd_cnt; c0 = cyc;
    for (int i = 1; i <= 16; i++) send(27'(i), i == 16, 1'b0);
    chk("no_bubble_cycles", 256'(cyc - c0), 256'd16);
    idle();
    drain();
    chk("full_beats", 256'(obs.size() - b), 256'd2);
    if (obs.size() >= b + 2) begin
      chk("full_b0_lane0", 256'(lane_of(obs[b], 0)), 256'h1);
      chk("full_b0_lane7", 256'(lane_of(obs[b], 7)), 256'h8);
      chk("full_b0_keep", 256'(obs[b].keep), 256'hFFFFFFFF);
      chk("full_b0_last", 256'(obs[b].last), 256'd0);
      chk("full_b1_lane0", 256'(lane_of(obs[b+1], 0)), 256'h9);
      chk("full_b1_lane7", 256'(lane_of(obs[b+1], 7)), 256'h10);
      chk("full_b1_last", 256'(obs[b+1].last), 256'd1);
    end
    chk("full_pd_pulses", 256'(pd_cnt - p0), 256'd1);

    // Partial final beat.
    b = obs.size();
    send(27'h7FFFFFF, 1'b0, 1'b0);
    send(27'd5, 1'b0, 1'b0);
    send(27'd6, 1'b1, 1'b0);
    idle();
    drain();
    if (obs.size() >= b + 1) begin
      chk("part_lane0", 256'(lane_of(obs[b], 0)), 256'h07FFFFFF);
      chk("part_lane1", 256'(lane_of(obs[b], 1)), 256'h5);
      chk("part_lane2", 256'(lane_of(obs[b], 2)), 256'h6);
      chk("part_upper", obs[b].data >> 96, 256'd0);
      chk("part_keep", 256'(obs[b].keep), 256'h00000FFF);
      chk("part_last", 256'(obs[b].last), 256'd1);
    end else chk("part_beats", 256'(obs.size() - b), 256'd1);

    // Single-coefficient transfer, then a new transfer from lane 0.
    b = obs.size();
    send(27'd9, 1'b1, 1'b0);
    send(27'd10, 1'b0, 1'b0);
    send(27'd11, 1'b1, 1'b0);
    idle();
    drain();
    if (obs.size() >= b + 2) begin
      chk("single_keep", 256'(obs[b].keep), 256'h0000000F);
      chk("single_lane0", 256'(lane_of(obs[b], 0)), 256'h9);
      chk("next_lane0", 256'(lane_of(obs[b+1], 0)), 256'hA);
      chk("next_lane1", 256'(lane_of(obs[b+1], 1)), 256'hB);
      chk("next_keep", 256'(obs[b+1].keep), 256'h000000FF);
    end else chk("single_beats", 256'(obs.size() - b), 256'd2);

    // Backpressure: downstream stalls after the first beat, then releases.
    mode = 2;
    fork
      begin
        for (int i = 0; i < 64; i++) send(27'($urandom), i == 63, 1'b0);
        idle();
      end
      begin
        repeat (20) @(posedge aclk);
        @(negedge aclk);
        chk("stall_s_tready", 256'(bus.s_axis_tready), 256'd0);
        chk("stall_m_tvalid", 256'(bus.m_axis_tvalid), 256'd1);
        mode = 0;
      end
    join
    drain();

    // Random throttling on both sides.
    mode = 1;
    for (int i = 0; i < 1000; i++)
      send(27'($urandom), (i == 999) || ($urandom_range(0, 19) == 0), 1'b1);
    idle();
    mode = 0;
    drain();

    // Reset in the middle of an assembly.
    for (int i = 0; i < 5; i++) send(27'(100 + i), 1'b0, 1'b0);
    idle();
    areset_n = 1'b0;
    repeat (2) @(posedge aclk);
    #1 areset_n = 1'b1;
    @(posedge aclk);
    #1;
    b = obs.size();
    for (int i = 0; i < 8; i++) send(27'(200 + i), i == 7, 1'b0);
    idle();
    drain();
    chk("rst_beats", 256'(obs.size() - b), 256'd1);
    if (obs.size() >= b + 1) begin
      chk("rst_lane0", 256'(lane_of(obs[b], 0)), 256'd200);
      chk("rst_lane7", 256'(lane_of(obs[b], 7)), 256'd207);
    end

    chk("model_empty", 256'(exp_q.size() + part.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
